// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Arbitrates two requesters for a shared bank of D flip-flops. Each granted
// operation (LOAD, CLEAR, PRESET, READ) is applied to the bank, then the bank
// value is captured into rdata.
//
// Parameters
//   WIDTH      width of the shared flop bank
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   req        request, one bit per requester
//   op0, op1   operation per requester: 00 LOAD, 01 CLEAR, 10 PRESET, 11 READ
//   wdata0/1   load data per requester
//   gnt        one-hot grant (one cycle)
//   done       one-hot completion pulse, coincident with the rdata update
//   rdata      bank value captured after the operation
//   ff_d       data to the flop bank
//   ff_reset   active-high clear to the flop bank
//   ff_preset  active-high preset to the flop bank
//   ff_q       flop bank output
//
// Configuration
//   DFF_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie;
//                          otherwise ties are resolved round-robin.
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] ff_d,
    output logic             ff_reset,
    output logic             ff_preset,
    input  logic [WIDTH-1:0] ff_q
);

    typedef enum logic [1:0] {StIdle, StApply, StCapture} state_e;

    localparam logic [1:0] OpLoad   = 2'b00;
    localparam logic [1:0] OpClear  = 2'b01;
    localparam logic [1:0] OpPreset = 2'b10;
    localparam logic [1:0] OpRead   = 2'b11;

    state_e           state_q, state_d;
    logic             winner_q, winner_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             pick;

    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] ff_d_q, ff_d_d;
    logic             ff_reset_q, ff_reset_d;
    logic             ff_preset_q, ff_preset_d;

`ifndef DFF_ARB_FIXED_PRIO_EN
    logic             last_winner_q, last_winner_d;
`endif

    // Winner selection among the currently active requesters.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
`ifdef DFF_ARB_FIXED_PRIO_EN
            2'b11:   pick = 1'b0;
`else
            2'b11:   pick = ~last_winner_q;
`endif
            default: pick = 1'b0;
        endcase
    end

    // State register (also holds the registered outputs).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            winner_q      <= 1'b0;
            op_q          <= OpLoad;
            wdata_q       <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            ff_d_q        <= '0;
            ff_reset_q    <= 1'b1;
            ff_preset_q   <= 1'b0;
`ifndef DFF_ARB_FIXED_PRIO_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            ff_d_q        <= ff_d_d;
            ff_reset_q    <= ff_reset_d;
            ff_preset_q   <= ff_preset_d;
`ifndef DFF_ARB_FIXED_PRIO_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
`ifndef DFF_ARB_FIXED_PRIO_EN
        last_winner_d = last_winner_q;
`endif
        case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    state_d  = StApply;
                    winner_d = pick;
                    op_d     = pick ? op1 : op0;
                    wdata_d  = pick ? wdata1 : wdata0;
                end
            end
            StApply: state_d = StCapture;
            StCapture: begin
                state_d = StIdle;
`ifndef DFF_ARB_FIXED_PRIO_EN
                last_winner_d = winner_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic. The flop controls are registered on the edge that enters
    // APPLY so the bank captures them at the end of APPLY; that leaves CAPTURE
    // to sample the updated ff_q. gnt is the registered image of APPLY and
    // done the registered image of CAPTURE, so they land on consecutive cycles.
    always_comb begin
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        rdata_d     = rdata_q;
        ff_d_d      = ff_d_q;
        ff_reset_d  = 1'b0;
        ff_preset_d = 1'b0;

        if (state_q == StIdle && state_d == StApply) begin
            unique case (op_d)
                OpLoad:   ff_d_d = wdata_d;
                // D follows the forced value so the bank stays put afterwards.
                OpClear: begin
                    ff_reset_d = 1'b1;
                    ff_d_d     = '0;
                end
                OpPreset: begin
                    ff_preset_d = 1'b1;
                    ff_d_d      = '1;
                end
                OpRead:   ff_d_d = ff_q;
                default:  ff_d_d = ff_d_q;
            endcase
        end

        if (state_q == StApply) begin
            gnt_d = winner_q ? 2'b10 : 2'b01;
            if (op_q == OpLoad) begin
                ff_d_d = wdata_q;
            end
        end

        if (state_q == StCapture) begin
            done_d  = winner_q ? 2'b10 : 2'b01;
            rdata_d = ff_q;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ff_d      = ff_d_q;
    assign ff_reset  = ff_reset_q;
    assign ff_preset = ff_preset_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req, op0, op1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic [1:0]       gnt, done;
    logic [WIDTH-1:0] rdata, ff_d, ff_q;
    logic             ff_reset, ff_preset;
    logic [WIDTH-1:0] bank;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural flop bank driven by the arbiter.
    always @(posedge clk) begin
        if (ff_reset)       bank <= '0;
        else if (ff_preset) bank <= '1;
        else                bank <= ff_d;
    end
    assign ff_q = bank;

    dff_bank_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .ff_d      (ff_d),
        .ff_reset  (ff_reset),
        .ff_preset (ff_preset),
        .ff_q      (ff_q)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
        wdata0 = '0; wdata1 = '0;
        step();
        step();
        checks++;
        if (ff_reset !== 1'b1) begin
            errors++; $display("FAIL reset_ff_reset: got %b want 1", ff_reset);
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || ff_preset !== 1'b0 || ff_d !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b preset=%b ff_d=%h want 00 00 0 00",
                     gnt, done, ff_preset, ff_d);
        end
        reset = 1'b1;
        step();
        checks++;
        if (ff_reset !== 1'b0) begin
            errors++; $display("FAIL reset_release: ff_reset got %b want 0", ff_reset);
        end
        // Idle with no requests: nothing happens.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== 2'b00 || done !== 2'b00 || ff_reset !== 1'b0 || ff_preset !== 1'b0
                || ff_q !== 8'h00) begin
                errors++;
                $display("FAIL idle_quiet: gnt=%b done=%b rst=%b pre=%b q=%h want 00 00 0 0 00",
                         gnt, done, ff_reset, ff_preset, ff_q);
            end
        end
    endtask

    task automatic test_single_load;
        req = 2'b01; op0 = 2'b00; wdata0 = 8'hA5;
        step();
        // Later input changes must not disturb the operation in flight.
        req = 2'b00; op0 = 2'b01; wdata0 = 8'hFF;
        checks++;
        if (ff_d !== 8'hA5 || gnt !== 2'b00) begin
            errors++; $display("FAIL load_apply: ff_d=%h gnt=%b want a5 00", ff_d, gnt);
        end
        step();
        checks++;
        if (gnt !== 2'b01 || done !== 2'b00) begin
            errors++; $display("FAIL load_gnt: gnt=%b done=%b want 01 00", gnt, done);
        end
        checks++;
        if (ff_d !== 8'hA5) begin
            errors++; $display("FAIL load_ff_d_hold: got %h want a5", ff_d);
        end
        step();
        checks++;
        if (done !== 2'b01 || rdata !== 8'hA5 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL load_done: done=%b rdata=%h gnt=%b want 01 a5 00", done, rdata, gnt);
        end
        step();
        step();
        checks++;
        if (done !== 2'b00 || rdata !== 8'hA5 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL load_hold: done=%b rdata=%h gnt=%b want 00 a5 00", done, rdata, gnt);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        // Fresh reset so last_winner starts at 1.
        reset = 1'b0;
        step();
        reset = 1'b1; req = 2'b11; op0 = 2'b00; op1 = 2'b00;
        wdata0 = 8'h11; wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_d = (exp_g == 2'b01) ? 8'h11 : 8'h22;
            step();
            step();
            checks++;
            if (gnt !== exp_g) begin
                errors++; $display("FAIL tie_gnt[%0d]: got %b want %b", i, gnt, exp_g);
            end
            step();
            checks++;
            if (done !== exp_g || rdata !== exp_d) begin
                errors++;
                $display("FAIL tie_done[%0d]: done=%b rdata=%h want %b %h",
                         i, done, rdata, exp_g, exp_d);
            end
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_clear_preset_read;
        logic [1:0] ops [3];
        logic [1:0] who [3];
        logic [7:0] exp [3];
        ops[0] = 2'b01; who[0] = 2'b10; exp[0] = 8'h00;
        ops[1] = 2'b10; who[1] = 2'b10; exp[1] = 8'hFF;
        ops[2] = 2'b11; who[2] = 2'b01; exp[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            req = who[i]; op0 = ops[i]; op1 = ops[i]; wdata0 = 8'h5A; wdata1 = 8'h5A;
            step();
            req = 2'b00;
            checks++;
            if (ff_reset !== (ops[i] == 2'b01) || ff_preset !== (ops[i] == 2'b10)) begin
                errors++;
                $display("FAIL ctl_apply[%0d]: rst=%b pre=%b want %b %b", i, ff_reset,
                         ff_preset, ops[i] == 2'b01, ops[i] == 2'b10);
            end
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (ff_reset === 1'b1 && ff_preset === 1'b1) begin
                    errors++; $display("FAIL ctl_exclusive[%0d]: rst=1 pre=1 want not both", i);
                end
            end
            checks++;
            if (done !== who[i] || rdata !== exp[i]) begin
                errors++;
                $display("FAIL ctl_result[%0d]: done=%b rdata=%h want %b %h",
                         i, done, rdata, who[i], exp[i]);
            end
        end
        step();
    endtask

    task automatic test_mid_reset;
        int seen_done;
        seen_done = 0;
        req = 2'b01; op0 = 2'b00; wdata0 = 8'h3C;
        step();
        reset = 1'b0; req = 2'b00;
        step();
        reset = 1'b1;
        if (done !== 2'b00) seen_done++;
        checks++;
        if (rdata !== 8'h00 || gnt !== 2'b00 || ff_reset !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: rdata=%h gnt=%b rst=%b want 00 00 1", rdata, gnt, ff_reset);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done !== 2'b00) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done);
        end
        req = 2'b01; op0 = 2'b11;
        step();
        req = 2'b00;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL abort_read_gnt: got %b want 01", gnt);
        end
        step();
        checks++;
        if (done !== 2'b01 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL abort_read: done=%b rdata=%h want 01 00", done, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_clear_preset_read();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
